// File: rtl/vec_assembler.sv
// Packs a valid/ready stream of BUS_WIDTH-bit words into VECTOR_WIDTH-bit vectors for bit_cntr,
// with a latency-matched {valid,last} tag pipeline. Optional residual flush: define VEC_ASM_FLUSH_EN.
module vec_assembler #(
    parameter int BUS_WIDTH    = 512,
    parameter int VECTOR_WIDTH = 920,
    parameter int CNTR_LATENCY = 5
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [BUS_WIDTH-1:0]    i_Data,
    input  logic                    i_Valid,
    input  logic                    i_Last,
    output logic                    o_Ready,
    output logic [VECTOR_WIDTH-1:0] o_Vector,
    output logic                    o_VecValid,
    output logic                    o_VecLast,
    input  logic                    i_Ready,
    output logic                    o_CntrEn,
    output logic                    o_SumValid,
    output logic                    o_SumLast
);
    localparam int BUF_W  = BUS_WIDTH + VECTOR_WIDTH;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam logic [FILL_W-1:0] VW = FILL_W'(VECTOR_WIDTH);
    localparam logic [FILL_W-1:0] BW = FILL_W'(BUS_WIDTH);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                  state, state_next;
    logic [FILL_W-1:0]       fill, fill_next, fill_shifted;
    logic [BUF_W-1:0]        buffer, buffer_next;
    logic                    full, vec_valid, vec_last, fire, ready, accept;
    logic [CNTR_LATENCY-1:0] tag_vld, tag_last;

    always_comb begin
        full      = (fill >= VW);
        vec_valid = full;
        vec_last  = 1'b0;
`ifdef VEC_ASM_FLUSH_EN
        if (state == DRAIN) begin
            vec_valid = (fill != '0);
            vec_last  = (fill <= VW);
        end
`else
        // In FILL the vector firing alongside the frame's final word is the last one
        // whenever what remains after that word cannot make another full vector.
        if (state == FILL)
            vec_last = i_Valid && i_Last &&
                       ((int'(fill) + BUS_WIDTH - VECTOR_WIDTH) < VECTOR_WIDTH);
        else
            vec_last = (int'(fill) < 2 * VECTOR_WIDTH);
`endif
        vec_valid = vec_valid && rstn;
        vec_last  = vec_last && vec_valid;
        fire      = vec_valid && i_Ready;

        fill_shifted = fill;
        if (fire)
            fill_shifted = (fill > VW) ? fill - VW : '0;
        ready  = rstn && (state == FILL) && (fill_shifted < VW);
        accept = i_Valid && ready;

        buffer_next = fire ? (buffer >> VECTOR_WIDTH) : buffer;
        if (accept)
            buffer_next[fill_shifted +: BUS_WIDTH] = i_Data;
        fill_next  = accept ? fill_shifted + BW : fill_shifted;
        state_next = state;

        case (state)
            FILL: begin
                if (accept && i_Last)
                    state_next = DRAIN;
            end
            DRAIN: begin
                // Residual bits never carry into the next frame.
                if (i_Ready) begin
                    if (!vec_valid) begin
                        fill_next  = '0;
                        state_next = FILL;
                    end
`ifdef VEC_ASM_FLUSH_EN
                    else if (fill <= VW) begin
                        fill_next  = '0;
                        state_next = FILL;
                    end
`endif
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= FILL;
            fill  <= '0;
        end else begin
            state <= state_next;
            fill  <= fill_next;
        end
    end

    always_ff @(posedge clk) begin
        buffer <= buffer_next;
    end

    // Tag pipeline mirrors the counter's register stages and advances with it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tag_vld  <= '0;
            tag_last <= '0;
        end else if (i_Ready) begin
            tag_vld[0]  <= fire;
            tag_last[0] <= fire && vec_last;
            for (int i = 1; i < CNTR_LATENCY; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_last[i] <= tag_last[i-1];
            end
        end
    end

`ifdef VEC_ASM_FLUSH_EN
    logic [VECTOR_WIDTH-1:0] vec_mask;
    assign vec_mask = full ? '1 : ~({VECTOR_WIDTH{1'b1}} << fill);
    assign o_Vector = buffer[VECTOR_WIDTH-1:0] & vec_mask;
`else
    assign o_Vector = buffer[VECTOR_WIDTH-1:0];
`endif

    assign o_Ready    = ready;
    assign o_VecValid = vec_valid;
    assign o_VecLast  = vec_last;
    assign o_CntrEn   = i_Ready;
    assign o_SumValid = rstn && i_Ready && tag_vld[CNTR_LATENCY-1];
    assign o_SumLast  = rstn && i_Ready && tag_last[CNTR_LATENCY-1];
endmodule

// File: tb/tb_vec_assembler.sv
// Self-checking bench for vec_assembler: frame-level bit-packing model plus a ready-counted tag latency model.
module tb_vec_assembler;
    localparam int BW = 512;
    localparam int VW = 920;
    localparam int L  = 5;
    localparam int HMAX = 4096;
`ifdef VEC_ASM_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic [BW-1:0] i_Data;
    logic          i_Valid, i_Last, i_Ready;
    logic          o_Ready, o_VecValid, o_VecLast, o_CntrEn, o_SumValid, o_SumLast;
    logic [VW-1:0] o_Vector;

    vec_assembler #(.BUS_WIDTH(BW), .VECTOR_WIDTH(VW), .CNTR_LATENCY(L)) dut (
        .clk(clk), .rstn(rstn), .i_Data(i_Data), .i_Valid(i_Valid), .i_Last(i_Last),
        .o_Ready(o_Ready), .o_Vector(o_Vector), .o_VecValid(o_VecValid), .o_VecLast(o_VecLast),
        .i_Ready(i_Ready), .o_CntrEn(o_CntrEn), .o_SumValid(o_SumValid), .o_SumLast(o_SumLast)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] v;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    logic [VW-1:0] got_q[$];
    logic [BW-1:0] fw [0:15];
    logic [1:0]    hist [0:HMAX-1];
    int            n_cmp = 0, n_fail = 0;
    int            fire_cnt = 0, sv_cnt = 0, sl_cnt = 0, rdy_cnt = 0;
    bit            started = 1'b0;

    function automatic void chk(input bit ok, input string nm,
                                input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endfunction

    // Concatenate the frame's words LSB-first and cut it into vectors.
    function automatic void push_frame(input int n);
        int   total, nvec, idx;
        exp_t e;
        total = n * BW;
        nvec  = FLUSH ? (total + VW - 1) / VW : total / VW;
        for (int v = 0; v < nvec; v++) begin
            for (int b = 0; b < VW; b++) begin
                idx = v * VW + b;
                e.v[b] = (idx < total) ? fw[idx / BW][idx % BW] : 1'b0;
            end
            e.last = (v == nvec - 1);
            exp_q.push_back(e);
        end
    endfunction

    function automatic logic [BW-1:0] rand_word();
        logic [BW-1:0] r;
        for (int k = 0; k < BW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Compare process: vectors against the model queue, sum tags against fires L ready-cycles ago.
    always @(negedge clk) begin
        logic esv, esl, fire, elast;
        exp_t e;
        if (!rstn) begin
            rdy_cnt = 0;
            started = 1'b1;
        end else if (started) begin
            esv = 1'b0;
            esl = 1'b0;
            if (i_Ready && rdy_cnt >= L) {esv, esl} = hist[rdy_cnt - L];
            chk({o_SumValid, o_SumLast} === {esv, esl}, "sum_tag",
                VW'({o_SumValid, o_SumLast}), VW'({esv, esl}));
            fire  = (o_VecValid === 1'b1) && i_Ready;
            elast = 1'b0;
            if (fire) begin
                fire_cnt++;
                got_q.push_back(o_Vector);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "no_exp", o_Vector, '0);
                end else begin
                    e = exp_q.pop_front();
                    elast = e.last;
                    chk(o_Vector === e.v, "vec", o_Vector, e.v);
                    chk(o_VecLast === e.last, "vec_last", VW'(o_VecLast), VW'(e.last));
                end
            end
            if (o_SumValid === 1'b1) sv_cnt++;
            if (o_SumLast === 1'b1) sl_cnt++;
            if (i_Ready) begin
                hist[rdy_cnt] = {fire, fire && elast};
                if (rdy_cnt < HMAX - 1) rdy_cnt++;
            end
        end
    end

    task automatic send(input logic [BW-1:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        i_Valid = 1'b1;
        i_Data  = d;
        i_Last  = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (o_Ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(1'b0, "accept_tmo", '0, VW'(1));
        @(posedge clk);
        #1;
        i_Valid = 1'b0;
        i_Last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({o_Ready, o_VecValid, o_VecLast, o_SumValid, o_SumLast} === 5'b0, nm,
            VW'({o_Ready, o_VecValid, o_VecLast, o_SumValid, o_SumLast}), '0);
    endtask

    initial begin
        int fb, sb, lb, gb;
        logic [VW-1:0] snap, ref_v;
        rstn = 1'b0; i_Valid = 1'b0; i_Last = 1'b0; i_Data = '0; i_Ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset_outs");
        rstn = 1'b1;

        // 9 all-ones words: 4608 bits -> 5 full vectors (flush: plus one 8-bit residual).
        fb = fire_cnt; sb = sv_cnt; lb = sl_cnt; gb = got_q.size();
        for (int i = 0; i < 9; i++) fw[i] = '1;
        push_frame(9);
        for (int i = 0; i < 9; i++) send(fw[i], i == 8);
        idle(20);
        chk(fire_cnt - fb == (FLUSH ? 6 : 5), "t1_fires", VW'(fire_cnt - fb), VW'(FLUSH ? 6 : 5));
        chk(sv_cnt - sb == (FLUSH ? 6 : 5), "t1_sumvalid", VW'(sv_cnt - sb), VW'(FLUSH ? 6 : 5));
        chk(sl_cnt - lb == 1, "t1_sumlast", VW'(sl_cnt - lb), VW'(1));
        ref_v = '1;
        chk(got_q[gb] === ref_v, "t1_ones", got_q[gb], ref_v);

        // Random 4-word frame: vector boundary falls at B[408].
        gb = got_q.size();
        for (int i = 0; i < 4; i++) fw[i] = rand_word();
        push_frame(4);
        for (int i = 0; i < 4; i++) send(fw[i], i == 3);
        idle(20);
        ref_v = {fw[1][407:0], fw[0]};
        chk(got_q[gb] === ref_v, "t2_v0", got_q[gb], ref_v);
        ref_v = {fw[3][303:0], fw[2], fw[1][511:408]};
        chk(got_q[gb+1] === ref_v, "t2_v1", got_q[gb+1], ref_v);

        // Stall with a full vector presented and a tag in flight.
        for (int i = 0; i < 6; i++) fw[i] = rand_word();
        push_frame(6);
        for (int i = 0; i < 4; i++) send(fw[i], 1'b0);
        i_Ready = 1'b0;
        i_Valid = 1'b1;
        i_Data  = fw[4];
        @(negedge clk);
        snap = o_Vector;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk(o_Vector === snap, "stall_vec", o_Vector, snap);
            chk({o_VecValid, o_Ready} === 2'b10, "stall_flags", VW'({o_VecValid, o_Ready}), VW'(2));
        end
        @(posedge clk);
        #1;
        i_Ready = 1'b1;
        send(fw[4], 1'b0);
        send(fw[5], 1'b1);
        idle(20);

        // 2-word frame.
        fb = fire_cnt; gb = got_q.size();
        fw[0] = rand_word(); fw[1] = rand_word();
        push_frame(2);
        send(fw[0], 1'b0);
        send(fw[1], 1'b1);
        idle(20);
        chk(fire_cnt - fb == (FLUSH ? 2 : 1), "t4_fires", VW'(fire_cnt - fb), VW'(FLUSH ? 2 : 1));
        ref_v = {fw[1][407:0], fw[0]};
        chk(got_q[gb] === ref_v, "t4_v0", got_q[gb], ref_v);
        if (FLUSH) begin
            ref_v = {{(VW-104){1'b0}}, fw[1][511:408]};
            chk(got_q[gb+1] === ref_v, "t4_flush", got_q[gb+1], ref_v);
        end

        // Reset after 3 words of an unterminated frame.
        for (int i = 0; i < 3; i++) fw[i] = rand_word();
        exp_q.push_back('{v: {fw[1][407:0], fw[0]}, last: 1'b0});
        for (int i = 0; i < 3; i++) send(fw[i], 1'b0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outs("t5_reset_outs");
        rstn = 1'b1;
        chk(exp_q.size() == 0, "t5_pending", VW'(exp_q.size()), '0);
        gb = got_q.size();
        fw[0] = rand_word(); fw[1] = rand_word();
        push_frame(2);
        send(fw[0], 1'b0);
        send(fw[1], 1'b1);
        idle(20);
        ref_v = {fw[1][407:0], fw[0]};
        chk(got_q[gb] === ref_v, "t5_v0", got_q[gb], ref_v);

        // 3-word frame: the only full vector fires together with the final word.
        fb = fire_cnt; lb = sl_cnt;
        for (int i = 0; i < 3; i++) fw[i] = rand_word();
        push_frame(3);
        for (int i = 0; i < 3; i++) send(fw[i], i == 2);
        idle(20);
        chk(fire_cnt - fb == (FLUSH ? 2 : 1), "t6_fires", VW'(fire_cnt - fb), VW'(FLUSH ? 2 : 1));
        chk(sl_cnt - lb == 1, "t6_sumlast", VW'(sl_cnt - lb), VW'(1));

        chk(exp_q.size() == 0, "leftover_exp", VW'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
